// File: rtl/flashrom_arb_pkg.sv
// Shared types and constants for the two-requester flash ROM read arbiter.
package flashrom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          NUM_REQ          = 2;
    localparam int          TO_CNT_W         = 16;

endpackage

// File: rtl/flashrom_arb_rr_arbiter2.sv
// Two-way round-robin grant: combinational pick, pointer updated on accept.
import flashrom_arb_pkg::*;

module rr_arbiter2 (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               accept,
    output logic               grant,
    output logic               any_valid
);

    logic last_grant;

    always_comb begin
        any_valid = |valid;
        grant     = 1'b0;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant;
    end

endmodule

// File: rtl/flashrom_arb.sv
// Round-robin arbiter sharing one single-beat flash read port between two requesters.
// Optional downstream timeout recovery is enabled with FLASHROM_ARB_TIMEOUT_EN.
import flashrom_arb_pkg::*;

module flashrom_arb #(
    parameter int          ADDR_W         = 24,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_valid,
    input  logic [ADDR_W-1:0] s0_addr,
    output logic              s0_ready,
    output logic [31:0]       s0_rdata,
    input  logic              s1_valid,
    input  logic [ADDR_W-1:0] s1_addr,
    output logic              s1_ready,
    output logic [31:0]       s1_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        grant, any_valid, accept;
    logic        expired, to_flag;
    logic [31:0] rd_next;

    assign accept  = (state == ST_IDLE) && any_valid;
    assign rd_next = m_ready ? m_rdata : ERR_DATA;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .valid     ({s1_valid, s0_valid}),
        .accept    (accept),
        .grant     (grant),
        .any_valid (any_valid)
    );

`ifdef FLASHROM_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;

    assign expired = (to_cnt == TO_LIMIT);

    // Counter runs only while waiting in REQ; to_flag marks the RESP cycle as an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (accept) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (state == ST_REQ) begin
            to_cnt  <= to_cnt + 1'b1;
            to_flag <= expired && !m_ready;
        end
    end
`else
    logic [TO_CNT_W-1:0] unused_to_limit;

    assign unused_to_limit = TO_LIMIT;
    assign expired         = 1'b0;
    assign to_flag         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_valid) state_next = ST_REQ;
            ST_REQ:  if (m_ready || expired) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid     = (state == ST_REQ);
        busy        = (state != ST_IDLE);
        s0_ready    = (state == ST_RESP) && !owner;
        s1_ready    = (state == ST_RESP) && owner;
        timeout_err = (state == ST_RESP) && to_flag;
    end

    // Address and owner latch at grant; each rdata only changes on its own completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= 1'b0;
            m_addr   <= '0;
            s0_rdata <= '0;
            s1_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        owner  <= grant;
                        m_addr <= grant ? s1_addr : s0_addr;
                    end
                end
                ST_REQ: begin
                    if (m_ready || expired) begin
                        if (owner)
                            s1_rdata <= rd_next;
                        else
                            s0_rdata <= rd_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flashrom_arb.sv
// Directed self-checking bench for flashrom_arb (timeout steps follow FLASHROM_ARB_TIMEOUT_EN).
module tb_flashrom_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        s0_valid, s1_valid, m_ready;
    logic [23:0] s0_addr, s1_addr;
    logic [31:0] m_rdata;
    logic        s0_ready, s1_ready, m_valid, busy, owner, timeout_err;
    logic [31:0] s0_rdata, s1_rdata;
    logic [23:0] m_addr;
    logic        exp_own;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flashrom_arb #(
        .ADDR_W         (24),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s0_valid    (s0_valid),
        .s0_addr     (s0_addr),
        .s0_ready    (s0_ready),
        .s0_rdata    (s0_rdata),
        .s1_valid    (s1_valid),
        .s1_addr     (s1_addr),
        .s1_ready    (s1_ready),
        .s1_rdata    (s1_rdata),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
        s0_addr = '0; s1_addr = '0; m_rdata = '0;
        tick(); tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_s0_ready", 32'(s0_ready), 32'd0);
        check("rst_s1_ready", 32'(s1_ready), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_s0_rdata", s0_rdata, 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        reset = 1'b0;

        // Single s0 read, ack one cycle after m_valid
        s0_valid = 1'b1; s0_addr = 24'h100010;
        tick();
        check("t1_m_valid", 32'(m_valid), 32'd1);
        check("t1_m_addr", 32'(m_addr), 32'h0010_0010);
        check("t1_owner", 32'(owner), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        m_ready = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        m_ready = 1'b0; m_rdata = '0;
        check("t1_s0_ready", 32'(s0_ready), 32'd1);
        check("t1_s0_rdata", s0_rdata, 32'h1234_5678);
        check("t1_s1_ready", 32'(s1_ready), 32'd0);
        check("t1_m_valid_drop", 32'(m_valid), 32'd0);
        s0_valid = 1'b0;
        tick();
        check("t1_s0_ready_end", 32'(s0_ready), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_s0_rdata_hold", s0_rdata, 32'h1234_5678);

        // Both requesters held valid from reset: strict alternation
        reset = 1'b1; tick(); reset = 1'b0;
        s0_addr = 24'h000100; s1_addr = 24'h000200;
        s0_valid = 1'b1; s1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_own = i[0];
            tick();
            check("t2_owner", 32'(owner), 32'(exp_own));
            check("t2_m_valid", 32'(m_valid), 32'd1);
            check("t2_m_addr", 32'(m_addr), exp_own ? 32'h200 : 32'h100);
            m_ready = 1'b1; m_rdata = 32'hC0DE_0000 + i;
            tick();
            m_ready = 1'b0;
            check("t2_own_ready", 32'(exp_own ? s1_ready : s0_ready), 32'd1);
            check("t2_other_ready", 32'(exp_own ? s0_ready : s1_ready), 32'd0);
            check("t2_rdata", exp_own ? s1_rdata : s0_rdata, 32'hC0DE_0000 + i);
            tick();
            check("t2_idle_busy", 32'(busy), 32'd0);
            check("t2_idle_m_valid", 32'(m_valid), 32'd0);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;

        // Asynchronous reset mid-REQ, late m_ready ignored
        s1_valid = 1'b1; s1_addr = 24'h0000F0;
        tick();
        check("t3_m_valid", 32'(m_valid), 32'd1);
        check("t3_owner", 32'(owner), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t3_async_m_valid", 32'(m_valid), 32'd0);
        check("t3_async_busy", 32'(busy), 32'd0);
        m_ready = 1'b1; m_rdata = 32'h1111_1111; s1_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_s0_ready", 32'(s0_ready), 32'd0);
        check("t3_s1_ready", 32'(s1_ready), 32'd0);
        check("t3_s1_rdata", s1_rdata, 32'd0);
        check("t3_m_valid", 32'(m_valid), 32'd0);
        m_ready = 1'b0; m_rdata = '0;

        // s1 drops valid during REQ; transaction still completes
        s1_valid = 1'b1; s1_addr = 24'h2000AC;
        tick();
        check("t4_owner", 32'(owner), 32'd1);
        check("t4_m_addr", 32'(m_addr), 32'h0020_00AC);
        s1_valid = 1'b0;
        tick();
        check("t4_m_valid_hold", 32'(m_valid), 32'd1);
        check("t4_busy_hold", 32'(busy), 32'd1);
        m_ready = 1'b1; m_rdata = 32'hA5A5_A5A5;
        tick();
        m_ready = 1'b0;
        check("t4_s1_ready", 32'(s1_ready), 32'd1);
        check("t4_s1_rdata", s1_rdata, 32'hA5A5_A5A5);
        check("t4_s0_ready", 32'(s0_ready), 32'd0);
        tick();
        check("t4_busy_end", 32'(busy), 32'd0);
        check("t4_s1_ready_end", 32'(s1_ready), 32'd0);
        check("t4_s0_rdata_hold", s0_rdata, 32'd0);

        // Downstream never acknowledges
        s0_valid = 1'b1; s0_addr = 24'h300000;
        tick();
        check("t5_m_valid", 32'(m_valid), 32'd1);
        check("t5_m_addr", 32'(m_addr), 32'h0030_0000);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t5_wait_m_valid", 32'(m_valid), 32'd1);
        end
`ifdef FLASHROM_ARB_TIMEOUT_EN
        tick();
        check("t5_s0_ready", 32'(s0_ready), 32'd1);
        check("t5_s0_rdata", s0_rdata, 32'hDEAD_BEEF);
        check("t5_timeout_err", 32'(timeout_err), 32'd1);
        check("t5_m_valid_drop", 32'(m_valid), 32'd0);
        s0_valid = 1'b0;
        tick();
        check("t5_timeout_err_end", 32'(timeout_err), 32'd0);
        check("t5_busy_end", 32'(busy), 32'd0);
`else
        for (int i = 0; i < 13; i++) begin
            tick();
            check("t5_hang_m_valid", 32'(m_valid), 32'd1);
            check("t5_hang_s0_ready", 32'(s0_ready), 32'd0);
            check("t5_hang_timeout_err", 32'(timeout_err), 32'd0);
        end
        s0_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
`endif

        // m_ready arrives on the expiry cycle: normal completion wins
        s0_valid = 1'b1; s0_addr = 24'h300004;
        tick();
        check("t6_m_valid", 32'(m_valid), 32'd1);
        repeat (7) tick();
        check("t6_m_valid_late", 32'(m_valid), 32'd1);
        m_ready = 1'b1; m_rdata = 32'h0000_CAFE;
        tick();
        m_ready = 1'b0;
        check("t6_s0_ready", 32'(s0_ready), 32'd1);
        check("t6_s0_rdata", s0_rdata, 32'h0000_CAFE);
        check("t6_timeout_err", 32'(timeout_err), 32'd0);
        s0_valid = 1'b0;
        tick();
        check("t6_busy_end", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
